alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
Downstream stage of the 8-bit add/sub unit. It captures the unit's registered result (sum, carry-out, opcode) when the unit raises its valid level, then writes the result into an 8-entry register file and updates the status flags. It also provides two asynchronous read ports that feed the add/sub operand inputs a and b, closing the datapath loop.

Parameters:
DATA_W, 8, width of result and register entries
NREGS, 8, number of register-file entries
ADDR_W, 3, register address width (log2 NREGS)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, synchronous, active-low
res_valid  input  1  result-valid level from add/sub (its ctr2); held high for one or more cycles
res_data  input  DATA_W  result from add/sub (its sum1)
res_cout  input  1  carry-out from add/sub (its cout1)
res_op  input  4  opcode presented to add/sub (its ctrl)
wr_addr  input  ADDR_W  destination register, sampled at capture
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
rd_data_a  output  DATA_W  regfile[rd_addr_a], combinational
rd_data_b  output  DATA_W  regfile[rd_addr_b], combinational
flag_c  output  1  carry (add) / borrow (sub) flag
flag_z  output  1  zero flag
flag_n  output  1  sign flag, equal to result bit DATA_W-1
wb_done  output  1  one-cycle pulse when a write commits
wb_count  output  8  number of committed writebacks, wraps

Behaviour:
- Reset, when rst_n=0 at a clk edge: every regfile entry is 0, flag_c/z/n are 0, wb_done is 0, wb_count is 0, state is IDLE, valid_q is 1.
- valid_q resets to 1. After reset, res_valid must be seen low before the first capture, so a level already high at reset release is ignored.
- Edge detect: valid_q <= res_valid every cycle. A capture event occurs when state=IDLE, res_valid=1 and valid_q=0.
- Opcode classes:
  - Add ops 2, 5, 7: flag_c = res_cout.
  - Sub ops 3, 6, 9: flag_c = ~res_cout, which is the borrow.
  - Any other opcode: the event is ignored. No write, no flag change, no wb_done. The FSM goes to HOLD.
- FSM states IDLE, WRITE, HOLD:
  - IDLE -> WRITE on a capture event with a valid opcode. At that edge, latch res_data, res_cout, res_op class and wr_addr into capture registers.
  - IDLE -> HOLD on a capture event with an invalid opcode.
  - WRITE -> HOLD, always, one cycle later. At this edge:
    - regfile[addr_cap] <= data_cap.
    - flag_z = (data_cap==0); flag_n = data_cap[DATA_W-1]; flag_c per opcode class.
    - wb_done = 1 for exactly this one cycle.
    - wb_count increments.
  - HOLD -> IDLE when res_valid=0. Stay in HOLD while res_valid=1, so a long valid level produces exactly one write.
- Latency: capture at edge k, commit at edge k+1, wb_done high between k+1 and k+2. Minimum spacing between two commits is 3 edges (k, k+1, then HOLD exits at k+2 if res_valid is already low; the next capture follows).
- Register 0 is hardwired to zero. A write to address 0 is discarded, but flags, wb_done and wb_count still update. rd_data for address 0 is always 0.
- Reads are asynchronous with no write bypass. A read of addr_cap during the WRITE cycle returns the old value, and the new value appears after edge k+1.
- Data inputs are sampled only at the capture edge. Later changes to res_data or wr_addr while in WRITE or HOLD have no effect.
- wb_count wraps from 255 to 0.
- A synchronous reset in any state returns to IDLE with the reset values above. A pending WRITE is aborted and nothing is written.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD_A=2, OP_SUB_A=3, OP_ADD_B=5, OP_SUB_B=6, OP_ADD_C=7, OP_SUB_C=9;
  - the FSM state encoding (IDLE=0, WRITE=1, HOLD=2);
  - DATA_W and ADDR_W defaults.
- One sub-module, wb_regfile: NREGS x DATA_W, one synchronous write port, two asynchronous read ports, r0 forced to zero.
- The FSM, edge detect and flags stay in alu_writeback.

Test Plan:
- Reset, then res_valid 0->1 for 3 cycles with res_op=2, res_data=8'h5A, res_cout=1, wr_addr=3 -> reg3=8'h5A, flag_c=1, flag_z=0, flag_n=0, exactly one wb_done pulse, wb_count=1.
- res_op=3, res_data=8'h00, res_cout=1 (5-5), wr_addr=4 -> reg4=0, flag_z=1, flag_c=0 (no borrow); then res_op=6, res_data=8'hFE, res_cout=0 -> flag_c=1, flag_n=1.
- Write to wr_addr=0 with res_data=8'h80, res_op=7 -> rd_data for address 0 stays 0, flag_n=1, wb_done pulses.
- res_op=4 with res_valid pulse -> regfile and flags unchanged, no wb_done, wb_count unchanged; FSM back to IDLE after res_valid falls.
- res_valid held high across reset release -> no write; a later 0->1 edge writes normally. Assert rst_n=0 in the WRITE cycle -> target register stays 0.
- 256 back-to-back valid pulses -> wb_count wraps to 0. Read rd_addr_a equal to the target during WRITE -> old value, new value on the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the add/sub writeback stage:
//   - default datapath widths (data width, register count, address width)
//   - add/sub opcode values presented on the unit's ctrl input
//   - writeback FSM state encoding
//   - opcode classification helper (add / sub / not-a-result)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_ADDR_W = 3;

  // Opcodes that produce a result worth committing.
  localparam logic [3:0] OP_ADD_A = 4'd2;
  localparam logic [3:0] OP_SUB_A = 4'd3;
  localparam logic [3:0] OP_ADD_B = 4'd5;
  localparam logic [3:0] OP_SUB_B = 4'd6;
  localparam logic [3:0] OP_ADD_C = 4'd7;
  localparam logic [3:0] OP_SUB_C = 4'd9;

  // Writeback FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    OPC_NONE = 2'd0,
    OPC_ADD  = 2'd1,
    OPC_SUB  = 2'd2
  } op_class_e;

  // Map a raw opcode onto the class that decides how carry-out becomes flag_c.
  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    cls = OPC_NONE;
    case (op)
      OP_ADD_A, OP_ADD_B, OP_ADD_C: cls = OPC_ADD;
      OP_SUB_A, OP_SUB_B, OP_SUB_C: cls = OPC_SUB;
      default:                      cls = OPC_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// NREGS x DATA_W register file with one synchronous write port and two
// asynchronous read ports. Entry 0 is hardwired to zero: writes to it are
// discarded and it always reads back 0.
//
// Ports:
//   clk        in   clock, writes on rising edge
//   rst_n      in   synchronous active-low reset, clears every entry
//   i_we       in   write enable
//   i_waddr    in   write address
//   i_wdata    in   write data
//   i_raddr_a  in   read port A address
//   i_raddr_b  in   read port B address
//   o_rdata_a  out  entry[i_raddr_a], combinational, no write bypass
//   o_rdata_b  out  entry[i_raddr_b], combinational, no write bypass
// -----------------------------------------------------------------------------
module wb_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  // Flattened view of all entries for the read muxes; slot 0 is a constant.
  logic [DATA_W-1:0] w_entries [NREGS];

  assign w_entries[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_entry
      logic [DATA_W-1:0] r_entry;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_entry <= '0;
        end else if (i_we && (i_waddr == ADDR_W'(gi))) begin
          r_entry <= i_wdata;
        end
      end

      assign w_entries[gi] = r_entry;
    end
  endgenerate

  assign o_rdata_a = w_entries[i_raddr_a];
  assign o_rdata_b = w_entries[i_raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
// Writeback stage behind the 8-bit add/sub unit. On a rising edge of the
// unit's valid level (seen while idle) it captures result, carry-out, opcode
// class and destination; one cycle later it commits the result to the
// register file, updates the C/Z/N flags, pulses wb_done and bumps wb_count.
// A long valid level produces a single write: the FSM parks in HOLD until
// the level drops. Two asynchronous read ports feed the unit's operands.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   res_valid  in   result-valid level from add/sub
//   res_data   in   result value
//   res_cout   in   carry-out of the add/sub
//   res_op     in   opcode presented to add/sub
//   wr_addr    in   destination register, sampled at capture
//   rd_addr_a  in   read port A address
//   rd_addr_b  in   read port B address
//   rd_data_a  out  regfile[rd_addr_a], combinational
//   rd_data_b  out  regfile[rd_addr_b], combinational
//   flag_c     out  carry (add) / borrow (sub)
//   flag_z     out  result was zero
//   flag_n     out  result MSB
//   wb_done    out  one-cycle pulse per committed write
//   wb_count   out  committed writebacks, wraps at 256
// -----------------------------------------------------------------------------
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_cout,
  input  logic [3:0]        res_op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n,
  output logic              wb_done,
  output logic [7:0]        wb_count
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_valid_q;
  logic [DATA_W-1:0] r_data_cap;
  logic              r_cout_cap;
  op_class_e         r_class_cap;
  logic [ADDR_W-1:0] r_addr_cap;
  logic              r_flag_c;
  logic              r_flag_z;
  logic              r_flag_n;
  logic              r_wb_done;
  logic [7:0]        r_wb_count;

  op_class_e         w_class;
  logic              w_capture;
  logic              w_commit;
  logic              w_flag_c_new;

  assign w_class   = op_class(res_op);

  // r_valid_q resets high, so a level already high at reset release is not
  // mistaken for a fresh rising edge.
  assign w_capture = (r_state == ST_IDLE) && res_valid && !r_valid_q;
  assign w_commit  = (r_state == ST_WRITE);

  // The add/sub unit reports carry-out; for subtraction no carry means borrow.
  assign w_flag_c_new = (r_class_cap == OPC_SUB) ? ~r_cout_cap : r_cout_cap;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_next = (w_class != OPC_NONE) ? ST_WRITE : ST_HOLD;
        end
      end
      ST_WRITE: w_state_next = ST_HOLD;
      ST_HOLD: begin
        if (!res_valid) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_valid_q   <= 1'b1;
      r_data_cap  <= '0;
      r_cout_cap  <= 1'b0;
      r_class_cap <= OPC_NONE;
      r_addr_cap  <= '0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_wb_done   <= 1'b0;
      r_wb_count  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_valid_q <= res_valid;
      r_wb_done <= w_commit;

      // Inputs are sampled only here; later changes are ignored.
      if (w_capture && (w_class != OPC_NONE)) begin
        r_data_cap  <= res_data;
        r_cout_cap  <= res_cout;
        r_class_cap <= w_class;
        r_addr_cap  <= wr_addr;
      end

      if (w_commit) begin
        r_flag_c   <= w_flag_c_new;
        r_flag_z   <= (r_data_cap == '0);
        r_flag_n   <= r_data_cap[DATA_W-1];
        r_wb_count <= r_wb_count + 8'd1;
      end
    end
  end

  // Writes to entry 0 are dropped inside the regfile; flags and count above
  // still update for them.
  wb_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_commit),
    .i_waddr   (r_addr_cap),
    .i_wdata   (r_data_cap),
    .i_raddr_a (rd_addr_a),
    .i_raddr_b (rd_addr_b),
    .o_rdata_a (rd_data_a),
    .o_rdata_b (rd_data_b)
  );

  assign flag_c   = r_flag_c;
  assign flag_z   = r_flag_z;
  assign flag_n   = r_flag_n;
  assign wb_done  = r_wb_done;
  assign wb_count = r_wb_count;

endmodule

// File: tb/tb_alu_writeback.sv
// -----------------------------------------------------------------------------
// tb_alu_writeback
// Self-checking bench for alu_writeback. A reference model (register array,
// flags and counter) is updated from the behavioural rules of the stage:
// only valid add/sub opcodes commit, entry 0 never changes, C is carry for
// adds and borrow for subs. Random results are generated from real operand
// pairs so that the expected carry/borrow also follows from plain arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_writeback;

  logic       clk;
  logic       rst_n;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_cout;
  logic [3:0] res_op;
  logic [2:0] wr_addr;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic       wb_done;
  logic [7:0] wb_count;

  int n_vec;
  int n_err;

  // Reference model state.
  logic [7:0] m_regs [8];
  logic       m_c;
  logic       m_z;
  logic       m_n;
  logic [7:0] m_cnt;

  alu_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_cout  (res_cout),
    .res_op    (res_op),
    .wr_addr   (wr_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .wb_done   (wb_done),
    .wb_count  (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic bit is_add(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd5) || (op == 4'd7);
  endfunction

  function automatic bit is_sub(input logic [3:0] op);
    return (op == 4'd3) || (op == 4'd6) || (op == 4'd9);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_cnt = 8'd0;
  endtask

  // Present one result with res_valid high for 'hi' cycles, then low for two
  // cycles so the stage is back in IDLE. Data and address are scrambled after
  // the capture edge. Returns the number of wb_done pulses seen.
  task automatic drive_pulse(input logic [3:0] op, input logic [7:0] data,
                             input logic cout, input logic [2:0] addr,
                             input int hi, output int dones);
    dones = 0;
    @(negedge clk);
    res_op = op; res_data = data; res_cout = cout; wr_addr = addr;
    res_valid = 1'b1;
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      if (wb_done) dones++;
      res_data = 8'($urandom);
      wr_addr  = 3'($urandom);
      res_cout = 1'($urandom);
    end
    res_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (wb_done) dones++;
    end
    if (is_add(op) || is_sub(op)) begin
      if (addr != 3'd0) m_regs[addr] = data;
      m_z = (data == 8'h00);
      m_n = data[7];
      m_c = is_sub(op) ? !cout : cout;
      m_cnt = m_cnt + 8'd1;
    end
    $display("pulse op=%0d data=%02h cout=%0d addr=%0d hi=%0d wb_done_pulses=%0d wb_count=%0d",
             op, data, cout, addr, hi, dones, wb_count);
  endtask

  task automatic test_reset();
    int dones;
    rst_n = 1'b0; res_valid = 1'b1; res_op = 4'd2; res_data = 8'hAA;
    res_cout = 1'b1; wr_addr = 3'd1; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (wb_done !== 1'b0 || wb_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_ctl: wb_done=%b wb_count=%0d, required 0/0", wb_done, wb_count);
    end
    n_vec++;
    if ({flag_c, flag_z, flag_n} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: czn=%b, required 000", {flag_c, flag_z, flag_n});
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i); #1;
      n_vec++;
      if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
        n_err++;
        $display("FAIL reset_reg%0d: a=%02h b=%02h, required 00/00", i, rd_data_a, rd_data_b);
      end
    end
    // Release reset with valid already high: must not capture.
    rst_n = 1'b1;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (wb_done) dones++;
    end
    res_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (wb_done) dones++;
    end
    rd_addr_a = 3'd1; #1;
    n_vec++;
    if (dones != 0 || wb_count !== 8'd0 || rd_data_a !== 8'h00) begin
      n_err++;
      $display("FAIL held_valid_at_release: pulses=%0d count=%0d reg1=%02h, required 0/0/00",
               dones, wb_count, rd_data_a);
    end
    $display("reset checked");
  endtask

  task automatic test_directed();
    int dones;
    drive_pulse(4'd2, 8'h5A, 1'b1, 3'd3, 3, dones);
    rd_addr_a = 3'd3; #1;
    n_vec++;
    if (dones != 1 || rd_data_a !== 8'h5A || wb_count !== 8'd1) begin
      n_err++;
      $display("FAIL add_basic: pulses=%0d reg3=%02h count=%0d, required 1/5a/1",
               dones, rd_data_a, wb_count);
    end
    n_vec++;
    if ({flag_c, flag_z, flag_n} !== 3'b100) begin
      n_err++;
      $display("FAIL add_flags: czn=%b, required 100", {flag_c, flag_z, flag_n});
    end

    drive_pulse(4'd3, 8'h00, 1'b1, 3'd4, 1, dones);
    rd_addr_b = 3'd4; #1;
    n_vec++;
    if (dones != 1 || rd_data_b !== 8'h00 || {flag_c, flag_z, flag_n} !== 3'b010) begin
      n_err++;
      $display("FAIL sub_zero: pulses=%0d reg4=%02h czn=%b, required 1/00/010",
               dones, rd_data_b, {flag_c, flag_z, flag_n});
    end

    drive_pulse(4'd6, 8'hFE, 1'b0, 3'd5, 2, dones);
    rd_addr_a = 3'd5; #1;
    n_vec++;
    if (dones != 1 || rd_data_a !== 8'hFE || {flag_c, flag_z, flag_n} !== 3'b101) begin
      n_err++;
      $display("FAIL sub_borrow: pulses=%0d reg5=%02h czn=%b, required 1/fe/101",
               dones, rd_data_a, {flag_c, flag_z, flag_n});
    end

    drive_pulse(4'd7, 8'h80, 1'b0, 3'd0, 1, dones);
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; #1;
    n_vec++;
    if (dones != 1 || rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || flag_n !== 1'b1 ||
        wb_count !== 8'd4) begin
      n_err++;
      $display("FAIL write_r0: pulses=%0d r0=%02h/%02h n=%b count=%0d, required 1/00/00/1/4",
               dones, rd_data_a, rd_data_b, flag_n, wb_count);
    end
  endtask

  task automatic test_invalid_op();
    int dones;
    logic [7:0] cnt_before;
    cnt_before = m_cnt;
    drive_pulse(4'd4, 8'h77, 1'b1, 3'd3, 2, dones);
    rd_addr_a = 3'd3; #1;
    n_vec++;
    if (dones != 0 || wb_count !== cnt_before || rd_data_a !== m_regs[3]) begin
      n_err++;
      $display("FAIL invalid_op: pulses=%0d count=%0d reg3=%02h, required 0/%0d/%02h",
               dones, wb_count, rd_data_a, cnt_before, m_regs[3]);
    end
    n_vec++;
    if ({flag_c, flag_z, flag_n} !== {m_c, m_z, m_n}) begin
      n_err++;
      $display("FAIL invalid_op_flags: czn=%b, required %b", {flag_c, flag_z, flag_n}, {m_c, m_z, m_n});
    end
    // Stage must be back in IDLE and accept the next result.
    drive_pulse(4'd5, 8'h11, 1'b0, 3'd2, 1, dones);
    rd_addr_a = 3'd2; #1;
    n_vec++;
    if (dones != 1 || rd_data_a !== 8'h11 || wb_count !== m_cnt) begin
      n_err++;
      $display("FAIL after_invalid: pulses=%0d reg2=%02h count=%0d, required 1/11/%0d",
               dones, rd_data_a, wb_count, m_cnt);
    end
  endtask

  task automatic test_read_during_write();
    int dones;
    logic [7:0] old_val;
    drive_pulse(4'd2, 8'h33, 1'b0, 3'd6, 1, dones);
    old_val = m_regs[6];
    @(negedge clk);
    res_op = 4'd5; res_data = 8'hC4; res_cout = 1'b1; wr_addr = 3'd6;
    res_valid = 1'b1; rd_addr_a = 3'd6;
    @(negedge clk);   // capture edge passed: WRITE cycle
    n_vec++;
    if (rd_data_a !== old_val) begin
      n_err++;
      $display("FAIL read_in_write: reg6=%02h, required %02h", rd_data_a, old_val);
    end
    @(negedge clk);   // commit edge passed
    n_vec++;
    if (rd_data_a !== 8'hC4 || wb_done !== 1'b1) begin
      n_err++;
      $display("FAIL read_after_write: reg6=%02h wb_done=%b, required c4/1", rd_data_a, wb_done);
    end
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    m_regs[6] = 8'hC4; m_c = 1'b1; m_z = 1'b0; m_n = 1'b1; m_cnt = m_cnt + 8'd1;
    n_vec++;
    if (wb_count !== m_cnt || {flag_c, flag_z, flag_n} !== {m_c, m_z, m_n}) begin
      n_err++;
      $display("FAIL rdw_state: count=%0d czn=%b, required %0d/%b",
               wb_count, {flag_c, flag_z, flag_n}, m_cnt, {m_c, m_z, m_n});
    end
    $display("read-during-write checked");
  endtask

  task automatic test_reset_in_write();
    @(negedge clk);
    res_op = 4'd2; res_data = 8'h99; res_cout = 1'b0; wr_addr = 3'd7; res_valid = 1'b1;
    @(negedge clk);   // WRITE cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; res_valid = 1'b0;
    model_reset();
    rd_addr_a = 3'd7; rd_addr_b = 3'd6; #1;
    n_vec++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || wb_done !== 1'b0 || wb_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_in_write: reg7=%02h reg6=%02h wb_done=%b count=%0d, required 00/00/0/0",
               rd_data_a, rd_data_b, wb_done, wb_count);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (rd_data_a !== 8'h00 || wb_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_abort_late: reg7=%02h count=%0d, required 00/0", rd_data_a, wb_count);
    end
    $display("reset during write checked");
  endtask

  task automatic test_back_to_back_wrap();
    int dones;
    logic [3:0] ops [6];
    logic [7:0] start;
    ops = '{4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9};
    start = m_cnt;
    for (int k = 0; k < 256; k++) begin
      drive_pulse(ops[$urandom_range(0, 5)], 8'($urandom), 1'($urandom),
                  3'($urandom), 1, dones);
      n_vec++;
      if (dones != 1 || wb_count !== m_cnt) begin
        n_err++;
        $display("FAIL b2b_%0d: pulses=%0d count=%0d, required 1/%0d", k, dones, wb_count, m_cnt);
      end
    end
    n_vec++;
    if (wb_count !== start) begin
      n_err++;
      $display("FAIL count_wrap: count=%0d, required %0d", wb_count, start);
    end
  endtask

  task automatic test_random();
    int dones;
    int a, b, r;
    logic [3:0] op;
    logic [7:0] data;
    logic cout, exp_c;
    logic [3:0] ops [8];
    ops = '{4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd4, 4'd11};
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 7)];
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (is_sub(op)) begin
        r = a + (255 - b) + 1;           // two's complement subtract
        exp_c = (a < b);                 // borrow
      end else begin
        r = a + b;
        exp_c = (r > 255);               // carry
      end
      data = 8'(r);
      cout = (r > 255);
      drive_pulse(op, data, cout, 3'($urandom), $urandom_range(1, 4), dones);
      n_vec++;
      if (dones != ((is_add(op) || is_sub(op)) ? 1 : 0) || wb_count !== m_cnt) begin
        n_err++;
        $display("FAIL rand_%0d_ctl: pulses=%0d count=%0d, required count %0d", k, dones, wb_count, m_cnt);
      end
      n_vec++;
      if ({flag_c, flag_z, flag_n} !== {m_c, m_z, m_n} ||
          ((is_add(op) || is_sub(op)) && flag_c !== exp_c)) begin
        n_err++;
        $display("FAIL rand_%0d_flags: czn=%b, required %b (arith c=%b)",
                 k, {flag_c, flag_z, flag_n}, {m_c, m_z, m_n}, exp_c);
      end
      for (int i = 0; i < 8; i++) begin
        rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i); #1;
        n_vec++;
        if (rd_data_a !== m_regs[i] || rd_data_b !== m_regs[7 - i]) begin
          n_err++;
          $display("FAIL rand_%0d_reg%0d: a=%02h b=%02h, required %02h/%02h",
                   k, i, rd_data_a, rd_data_b, m_regs[i], m_regs[7 - i]);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_invalid_op();
    test_read_during_write();
    test_reset_in_write();
    test_back_to_back_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
